// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
//   phase_t : BLANK (all anodes off) / SHOW (one digit driven)
//   slot_t  : digit slot; slot0=R3, slot1=R2, slot2=R1, slot3=letter
//   AN_*    : active-low anode patterns
package display_pkg;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_SLOT0 = 4'b0111;
    localparam logic [3:0] AN_SLOT1 = 4'b1011;
    localparam logic [3:0] AN_SLOT2 = 4'b1101;
    localparam logic [3:0] AN_SLOT3 = 4'b1110;

    function automatic logic [3:0] slot_anode(input slot_t s);
        case (s)
            SLOT0:   return AN_SLOT0;
            SLOT1:   return AN_SLOT1;
            SLOT2:   return AN_SLOT2;
            default: return AN_SLOT3;
        endcase
    endfunction

    // SEL code that selects the rotor shown in a slot. The letter slot maps
    // to 0, which is the "nothing selected" code, so it can never blink.
    function automatic logic [1:0] slot_sel_code(input slot_t s);
        case (s)
            SLOT0:   return 2'd3;
            SLOT1:   return 2'd2;
            SLOT2:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Phase duration timer: down-counter that reloads itself on terminal count.
//   i_clk, i_rst_n : clock, async active-low reset (count <- RST_VAL)
//   i_load_val     : value (duration-1) loaded when the count reaches zero
//   o_count        : current count
//   o_tc           : terminal count, high on the last cycle of a phase
module slot_timer #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= RST_VAL;
        end else if (r_count == '0) begin
            r_count <= i_load_val;
        end else begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/display_scheduler.sv
// Time-multiplexed 4-digit seven-segment scheduler for the Enigma panel.
// Each slot is a blanking gap followed by the digit; inputs are snapshotted
// once per frame, the edited rotor blinks, and the letter slot is skipped
// when no letter is valid.
//   CLK, RST_N        : clock, async active-low reset
//   ON                : letter valid (enables slot3)
//   SEL[1:0]          : rotor being edited (0 none, 1 R1, 2 R2, 3 R3)
//   R1, R2, R3, LET   : rotor positions and encrypted letter code
//   an[3:0]           : active-low anode enables
//   out[4:0]          : code for the segment decoder
//   frame_start       : pulse on the cycle the snapshot is taken
//
// state    | meaning
// PH_BLANK | all anodes off ahead of r_slot's digit
// PH_SHOW  | r_slot's digit driven (or dark while blinking)
module display_scheduler
    import display_pkg::*;
#(
    parameter int SHOW_CYCLES  = 100_000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ON,
    input  logic [1:0] SEL,
    input  logic [4:0] R1,
    input  logic [4:0] R2,
    input  logic [4:0] R3,
    input  logic [4:0] LET,
    output logic [3:0] an,
    output logic [4:0] out,
    output logic       frame_start
);

    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] BLANK_LD   = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LD    = CW'(SHOW_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    phase_t          r_phase, w_phase_nxt;
    slot_t           r_slot,  w_slot_nxt;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_load_val;
    logic            w_tc;
    logic            w_frame_start;
    logic            w_dark;

    logic [4:0]      r_r1, r_r2, r_r3, r_let;
    logic            r_on;
    logic [1:0]      r_sel;
    logic [FW-1:0]   r_frame;
    logic            r_blink_vis;
    logic            r_armed;

    // Reload value is the duration of the phase that follows the current one.
    assign w_load_val = (r_phase == PH_BLANK) ? SHOW_LD : BLANK_LD;

    slot_timer #(
        .W       (CW),
        .RST_VAL (BLANK_LD)
    ) u_slot_timer (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_tc       (w_tc)
    );

    // First BLANK cycle of slot0. Gated by RST_N so the pulse stays low while
    // reset is held, even though the registers already sit in that state.
    assign w_frame_start = RST_N && (r_phase == PH_BLANK) && (r_slot == SLOT0)
                           && (w_count == BLANK_LD);
    assign frame_start   = w_frame_start;

    assign w_dark = (r_sel != 2'd0) && (r_sel == slot_sel_code(r_slot)) && !r_blink_vis;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_phase <= PH_BLANK;
            r_slot  <= SLOT0;
        end else begin
            r_phase <= w_phase_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_slot_nxt  = r_slot;
        an          = AN_OFF;
        out         = '0;
        if (w_tc) begin
            if (r_phase == PH_BLANK) begin
                w_phase_nxt = PH_SHOW;
            end else begin
                w_phase_nxt = PH_BLANK;
                case (r_slot)
                    SLOT0:   w_slot_nxt = SLOT1;
                    SLOT1:   w_slot_nxt = SLOT2;
                    SLOT2:   w_slot_nxt = r_on ? SLOT3 : SLOT0;
                    default: w_slot_nxt = SLOT0;
                endcase
            end
        end
        if (r_phase == PH_SHOW && !w_dark) begin
            an = slot_anode(r_slot);
            case (r_slot)
                SLOT0:   out = r_r3;
                SLOT1:   out = r_r2;
                SLOT2:   out = r_r1;
                default: out = r_let;
            endcase
        end
    end

    // The frame counter counts completed frames; the first frame_start after
    // reset closes no frame, so blink_vis stays high for frames 0..N-1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_r1        <= '0;
            r_r2        <= '0;
            r_r3        <= '0;
            r_let       <= '0;
            r_on        <= 1'b0;
            r_sel       <= '0;
            r_frame     <= '0;
            r_blink_vis <= 1'b1;
            r_armed     <= 1'b0;
        end else if (w_frame_start) begin
            r_r1    <= R1;
            r_r2    <= R2;
            r_r3    <= R3;
            r_let   <= LET;
            r_on    <= ON;
            r_sel   <= SEL;
            r_armed <= 1'b1;
            if (r_armed) begin
                if (r_frame == FRAME_LAST) begin
                    r_frame     <= '0;
                    r_blink_vis <= ~r_blink_vis;
                end else begin
                    r_frame <= r_frame + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

    logic       CLK;
    logic       RST_N;
    logic       ON;
    logic [1:0] SEL;
    logic [4:0] R1, R2, R3, LET;
    logic [3:0] an;
    logic [4:0] out;
    logic       frame_start;

    int n_tests;
    int n_fail;
    int frame_no;

    localparam logic [3:0] AN_TAB [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    display_scheduler #(
        .SHOW_CYCLES  (4),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ON          (ON),
        .SEL         (SEL),
        .R1          (R1),
        .R2          (R2),
        .R3          (R3),
        .LET         (LET),
        .an          (an),
        .out         (out),
        .frame_start (frame_start)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks one whole frame cycle by cycle, starting on its frame_start cycle
    // and ending positioned on the first cycle of the next frame. At cycle
    // chg_at the inputs ON/SEL/R2 are changed to the given values.
    task automatic run_frame(input int nslots,
                             input logic [4:0] e0, input logic [4:0] e1,
                             input logic [4:0] e2, input logic [4:0] e3,
                             input int dark, input int chg_at,
                             input logic n_on, input logic [1:0] n_sel,
                             input logic [4:0] n_r2);
        logic [4:0] ev [4];
        logic [3:0] exp_an;
        logic [4:0] exp_out;
        int s, k;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int c = 0; c < nslots * 6; c++) begin
            s = c / 6;
            k = c % 6;
            if (k < 2 || s == dark) begin
                exp_an  = 4'b1111;
                exp_out = 5'd0;
            end else begin
                exp_an  = AN_TAB[s];
                exp_out = ev[s];
            end
            check($sformatf("f%0d c%0d fs", frame_no, c), 32'(frame_start), 32'(c == 0));
            check($sformatf("f%0d c%0d an", frame_no, c), 32'(an), 32'(exp_an));
            check($sformatf("f%0d c%0d out", frame_no, c), 32'(out), 32'(exp_out));
            if (c == chg_at) begin
                ON  = n_on;
                SEL = n_sel;
                R2  = n_r2;
            end
            @(posedge CLK);
            #1;
        end
        frame_no++;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        frame_no = 0;
        RST_N = 1'b0;
        ON    = 1'b1;
        SEL   = 2'd0;
        R3    = 5'd5;
        R2    = 5'd6;
        R1    = 5'd7;
        LET   = 5'd8;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_out", 32'(out), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);

        RST_N = 1'b1;
        #1;
        check("rel_fs", 32'(frame_start), 32'h1);

        // F0: R2 changes during slot0 SHOW, slot1 still shows 6
        run_frame(4, 5, 6, 7, 8, -1, 3, 1'b1, 2'd0, 5'd9);
        // F1: new R2 visible; drop ON mid-frame
        run_frame(4, 5, 9, 7, 8, -1, 1, 1'b0, 2'd0, 5'd9);
        // F2: 18-cycle frame, no letter slot; raise ON mid-frame
        run_frame(3, 5, 9, 7, 0, -1, 5, 1'b1, 2'd0, 5'd9);
        // F3: letter back; request blinking of R2
        run_frame(4, 5, 9, 7, 8, -1, 1, 1'b1, 2'd2, 5'd9);
        // F4, F5: blink visible half
        run_frame(4, 5, 9, 7, 8, -1, -1, 1'b1, 2'd2, 5'd9);
        run_frame(4, 5, 9, 7, 8, -1, -1, 1'b1, 2'd2, 5'd9);
        // F6: dark half, slot1 blank; deselect
        run_frame(4, 5, 9, 7, 8, 1, 1, 1'b1, 2'd0, 5'd9);
        // F7: dark half but SEL=0, nothing dark; reselect R2
        run_frame(4, 5, 9, 7, 8, -1, 1, 1'b1, 2'd2, 5'd9);
        // F8, F9 visible, F10 dark: frame counter kept running
        run_frame(4, 5, 9, 7, 8, -1, -1, 1'b1, 2'd2, 5'd9);
        run_frame(4, 5, 9, 7, 8, -1, -1, 1'b1, 2'd2, 5'd9);
        run_frame(4, 5, 9, 7, 8, 1, 1, 1'b1, 2'd3, 5'd9);
        // F11: dark half with SEL=3 -> slot0 dark
        run_frame(4, 5, 9, 7, 8, 0, -1, 1'b1, 2'd3, 5'd9);

        // F12 is a visible frame; assert reset in the middle of slot0 SHOW
        repeat (3) @(posedge CLK);
        #1;
        check("pre_rst_an", 32'(an), 32'(4'b0111));
        check("pre_rst_out", 32'(out), 32'd5);
        RST_N = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_fs", 32'(frame_start), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-multiplexing controller for the 4-digit seven-segment display of the Enigma front panel. It sequences the rotor positions (R3, R2, R1) and the encrypted letter onto the shared anode/segment-data bus. It inserts a blanking gap before every digit to suppress ghosting and snapshots all inputs once per frame to prevent tearing. It also blinks the rotor currently selected for editing and drops the letter digit from the frame when no letter is valid.

## Interface
Parameters:
- SHOW_CYCLES, 100_000: cycles a digit is driven per slot; must be ≥ 1.
- BLANK_CYCLES, 16: cycles all anodes are off before each digit; must be ≥ 1.
- BLINK_FRAMES, 128: frames per blink half-period; must be ≥ 1.

Ports:
- CLK  in  1  system clock. One clock domain.
- RST_N  in  1  reset, asynchronous, active-low.
- ON  in  1  encrypted letter valid; enables the fourth digit.
- SEL  in  2  rotor being edited: 0 none, 1 R1, 2 R2, 3 R3.
- R1, R2, R3  in  5 each  rotor positions, 0–25.
- LET  in  5  encrypted letter code.
- an  out  4  anode enables, active-low.
- out  out  5  code for the segment decoder.
- frame_start  out  1  one-cycle pulse on the cycle the snapshot is taken.

## Operation
- State registers: phase {BLANK, SHOW}, slot 0–3, cycle counter, snapshot registers (R1..R3, LET, ON, SEL), frame counter, blink_vis.
- Slot map:
  - slot0: an=0111, out=R3.
  - slot1: an=1011, out=R2.
  - slot2: an=1101, out=R1.
  - slot3: an=1110, out=LET.
- BLANK: an=1111, out=0, for BLANK_CYCLES cycles, then SHOW.
- SHOW: drive the slot-map values for SHOW_CYCLES cycles, then BLANK of the next slot.
- Next slot after slot2 is slot3 if snapshot ON=1, else slot0. Next slot after slot3 is always slot0.
- frame_start is high when phase=BLANK, slot=0 and counter=0. On that clock edge:
  - R1..R3, LET, ON and SEL are captured into the snapshot registers.
  - The frame counter increments. At BLINK_FRAMES-1 it wraps to 0 and toggles blink_vis.
- All mid-frame input changes, including ON and SEL, are ignored until the next frame_start.
- Blink: if snapshot SEL selects this slot's rotor and blink_vis=0, SHOW drives an=1111, out=0. The slot still consumes its full duration.
- SEL=0: no digit blinks. SEL never affects slot3.
- an and out are combinational decodes of registered state and snapshot only; no input reaches the outputs combinationally.

## Timing
- Reset (asynchronous assert): an=1111, out=0, frame_start=0. Also phase=BLANK, slot=0, counters=0, snapshots=0, blink_vis=1. All outputs reach these values immediately, even mid-SHOW.
- First cycle after RST_N rises: frame_start=1.
- Slot length = BLANK_CYCLES+SHOW_CYCLES. Frame length = 4 slots if snapshot ON=1, else 3.
- Input-to-display latency: values are visible at the first SHOW cycle of their slot in the frame following their capture.
- Blink half-period = BLINK_FRAMES frames. blink_vis is 1 for frames 0..BLINK_FRAMES-1 after reset.
- Exactly one an bit is low in SHOW; all an bits are high in BLANK. No cycle ever has two digits enabled.

## Structure
- Shared package display_pkg holds:
  - the phase enum;
  - the slot enum;
  - anode constants AN_OFF=4'b1111 and AN_SLOT0..AN_SLOT3.
- Sub-module slot_timer contains the cycle counter. It is loaded with BLANK_CYCLES or SHOW_CYCLES and emits a terminal-count pulse. The top level keeps the phase/slot FSM, the snapshot registers and the blink counter.

## Test plan
All scenarios use SHOW_CYCLES=4, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset: hold RST_N=0 → an=1111, out=0, frame_start=0. Release → frame_start=1 on the first cycle. Assert RST_N=0 mid-SHOW → an=1111 in the same cycle.
- ON=1, R3=5, R2=6, R1=7, LET=8 → sequence is 2×1111, 4×(0111,5), 2×1111, 4×(1011,6), 2×1111, 4×(1101,7), 2×1111, 4×(1110,8). frame_start recurs every 24 cycles.
- ON=0 → frame repeats every 18 cycles and an never equals 1110. Raising ON mid-frame → slot3 appears only from the next frame.
- Change R2 from 6 to 9 during slot0 SHOW → slot1 still shows 6. The next frame shows 9.
- SEL=2, ON=1 → slot1 shows (1011,R2) in frames 0–1 and an=1111, out=0 in frames 2–3, repeating. Slots 0, 2 and 3 are unaffected and frame length stays 24.
- SEL=0 after blinking → no dark slot from the next frame onward. The frame counter keeps running.
